// File: rtl/aeonic_spi_target.sv
// SPI mode-0 target with a small byte register file, oversampled in clk.
// Build option AEONIC_SPI_TGT_AUTOINC_EN: address auto-increment per data byte.
`timescale 1ns/1ps
module aeonic_spi_target #(
  parameter int          AW      = 4,
  parameter logic [7:0]  ID_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          n_ss,
  input  logic          sclk,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  output logic          wr_stb,
  output logic [AW-1:0] wr_addr,
  output logic          bad_cmd
);

  localparam int DEPTH = 1 << AW;

`ifdef AEONIC_SPI_TGT_AUTOINC_EN
  localparam logic [AW-1:0] ADDR_STEP = AW'(1);
`else
  localparam logic [AW-1:0] ADDR_STEP = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WDATA,
    S_RDATA,
    S_IGNORE
  } state_t;

  logic [1:0]    ss_s_q;
  logic [1:0]    sclk_s_q;
  logic [1:0]    mosi_s_q;
  logic          sclk_prev_q;
  logic          ss_prev_q;
  logic [1:0]    vld_q;
  logic          armed_q;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    tx_q, tx_d;
  logic          miso_q, miso_d;
  logic          id_q, id_d;
  logic          wr_q, wr_d;
  logic          wr_stb_q, wr_stb_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          bad_q, bad_d;

  logic [7:0]    mem_q [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  logic          ss_sync;
  logic          sclk_rise;
  logic          sclk_fall;
  logic          ss_fall;
  logic [7:0]    byte_in;
  logic          byte_done;
  logic [AW-1:0] byte_addr;

  // A select fall only counts once a genuine high level has been seen
  // after reset, so a reset in mid-transaction cannot restart the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_s_q      <= 2'b11;
      sclk_s_q    <= 2'b00;
      mosi_s_q    <= 2'b00;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      vld_q       <= 2'b00;
      armed_q     <= 1'b0;
    end else begin
      ss_s_q      <= {ss_s_q[0], n_ss};
      sclk_s_q    <= {sclk_s_q[0], sclk};
      mosi_s_q    <= {mosi_s_q[0], mosi};
      sclk_prev_q <= sclk_s_q[1];
      ss_prev_q   <= ss_s_q[1];
      vld_q       <= {vld_q[0], 1'b1};
      armed_q     <= armed_q | (vld_q[1] & ss_s_q[1]);
    end
  end

  assign ss_sync   = ss_s_q[1];
  assign sclk_rise = sclk_s_q[1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s_q[1] & sclk_prev_q;
  assign ss_fall   = armed_q & ss_prev_q & ~ss_sync;
  assign byte_in   = {sh_q[6:0], mosi_s_q[1]};
  assign byte_done = sclk_rise & (cnt_q == 3'd7);
  assign byte_addr = byte_in[AW-1:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    id_d      = id_q;
    wr_d      = wr_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    bad_d     = 1'b0;
    we        = 1'b0;
    waddr     = addr_q;
    wdata     = byte_in;
    if (state_q != S_IDLE && ss_sync) begin
      state_d = S_IDLE;
      cnt_d   = 3'd0;
      miso_d  = 1'b0;
    end else begin
      if (sclk_rise) begin
        sh_d  = byte_in;
        cnt_d = cnt_q + 3'd1;
      end
      unique case (state_q)
        S_IDLE: begin
          cnt_d  = 3'd0;
          miso_d = 1'b0;
          if (ss_fall) state_d = S_CMD;
        end
        S_CMD: begin
          miso_d = 1'b0;
          if (byte_done) begin
            unique case (1'b1)
              (byte_in == 8'h02): begin
                state_d = S_ADDR;
                wr_d    = 1'b1;
                id_d    = 1'b0;
              end
              (byte_in == 8'h03): begin
                state_d = S_ADDR;
                wr_d    = 1'b0;
                id_d    = 1'b0;
              end
              (byte_in == 8'h9F): begin
                state_d = S_RDATA;
                id_d    = 1'b1;
                tx_d    = ID_BYTE;
              end
              default: begin
                state_d = S_IGNORE;
                bad_d   = 1'b1;
              end
            endcase
          end
        end
        S_ADDR: begin
          miso_d = 1'b0;
          if (byte_done) begin
            if (wr_q) begin
              state_d = S_WDATA;
              addr_d  = byte_addr;
            end else begin
              state_d = S_RDATA;
              tx_d    = mem_q[byte_addr];
              addr_d  = byte_addr + ADDR_STEP;
            end
          end
        end
        S_WDATA: begin
          miso_d = 1'b0;
          if (byte_done) begin
            we        = 1'b1;
            wr_stb_d  = 1'b1;
            wr_addr_d = addr_q;
            addr_d    = addr_q + ADDR_STEP;
          end
        end
        S_RDATA: begin
          if (sclk_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
          if (byte_done) begin
            if (id_q) begin
              tx_d = ID_BYTE;
            end else begin
              tx_d   = mem_q[addr_q];
              addr_d = addr_q + ADDR_STEP;
            end
          end
        end
        S_IGNORE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      sh_q      <= 8'h00;
      addr_q    <= '0;
      tx_q      <= 8'h00;
      miso_q    <= 1'b0;
      id_q      <= 1'b0;
      wr_q      <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_addr_q <= '0;
      bad_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      id_q      <= id_d;
      wr_q      <= wr_d;
      wr_stb_q  <= wr_stb_d;
      wr_addr_q <= wr_addr_d;
      bad_q     <= bad_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = ~ss_sync;
  assign host_rdata = mem_q[host_addr];
  assign wr_stb     = wr_stb_q;
  assign wr_addr    = wr_addr_q;
  assign bad_cmd    = bad_q;

endmodule
